multadd_fp_ci_seq: RTL and testbench

Sequencer and accumulation controller that drives one `multadd_fp_ci` DSP instance in feedback mode, with its `fp32_result` routed back as `fp32_chainin`. It forms LATENCY interleaved fp32 dot products. Input beats arrive over a valid/ready stream, and each pass carries one beat per lane. The block handles pipeline enables, chain-in selection, pipeline tagging, draining between frames and an output FIFO. Completed sums go out over a valid/ready stream to downstream FDAS logic.

---
 rtl/multadd_fp_ci_seq_if.sv | 47 ++++
 rtl/multadd_fp_ci_seq.sv | 164 ++++++++++++++++
 tb/tb_multadd_fp_ci_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multadd_fp_ci_seq_if.sv
// multadd_fp_ci_seq_if
//   Bundles the signals of multadd_fp_ci_seq apart from clk/clr. These are
//   the input beat stream, the DSP control/data bus and the result stream.
//   slave  : the sequencer side (multadd_fp_ci_seq itself).
//   master : the environment side. It sources beats, models or wires the DSP,
//            and sinks results.
//   Signals:
//     in_valid/in_ready/in_a/in_b/in_first/in_last  input beat stream
//     ma_a/ma_b/ma_chainin/ma_ena/ma_clr0/ma_clr1    to the multadd_fp_ci DSP
//     ma_result                                      from the DSP
//     out_valid/out_ready/out_data/out_lane          completed sums
//     err_proto                                      sticky protocol error
//   LANE_W must equal the log2 of the sequencer's LATENCY.
interface multadd_fp_ci_seq_if #(
  parameter int LANE_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [31:0]       in_b;
  logic              in_first;
  logic              in_last;
  logic [31:0]       ma_a;
  logic [31:0]       ma_b;
  logic [31:0]       ma_chainin;
  logic [2:0]        ma_ena;
  logic              ma_clr0;
  logic              ma_clr1;
  logic [31:0]       ma_result;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [LANE_W-1:0] out_lane;
  logic              err_proto;

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, ma_result, out_ready,
    output in_ready, ma_a, ma_b, ma_chainin, ma_ena, ma_clr0, ma_clr1,
           out_valid, out_data, out_lane, err_proto
  );

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, ma_result, out_ready,
    input  in_ready, ma_a, ma_b, ma_chainin, ma_ena, ma_clr0, ma_clr1,
           out_valid, out_data, out_lane, err_proto
  );
endinterface

// File: rtl/multadd_fp_ci_seq.sv
// multadd_fp_ci_seq
//   Drives one multadd_fp_ci DSP in feedback mode, with fp32_result wired back
//   as the chain-in. It forms LATENCY interleaved fp32 dot products, one per
//   lane. Each pass of a frame carries one beat per lane, lanes 0..LATENCY-1
//   in order. Pass 0 starts from zero chain-in. Later passes add onto the
//   same lane's running sum, which leaves the DSP exactly LATENCY advances
//   after it was issued. Results of the final pass are queued in a
//   first-word-fall-through FIFO.
//   Ports:
//     clk  sole clock
//     clr  synchronous active-high reset. It also clears the DSP, one cycle
//          later, through ma_clr0/ma_clr1.
//     bus  multadd_fp_ci_seq_if.slave. It carries the input stream, the DSP
//          bus, the output stream and err_proto.
module multadd_fp_ci_seq #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic                clk,
  input logic                clr,
  multadd_fp_ci_seq_if.slave bus
);

  localparam int LANE_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LATENCY - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  logic [LANE_W-1:0]  lane_cnt;
  logic               prev_first;
  logic               prev_last;
  logic               err_q;
  logic               clr_q;

  // Tag pipe. Index 0 is the newest entry. Index LATENCY-1 lines up with
  // the DSP output.
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_last;
  logic [LANE_W-1:0]  tag_lane [LATENCY];

  logic [31:0]        fifo_data [FIFO_DEPTH];
  logic [LANE_W-1:0]  fifo_lane [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;

  logic fifo_full;
  logic fifo_nonempty;
  logic pop;
  logic space;
  logic issue;
  logic drain;
  logic adv;
  logic push;

  // Advance control. The DSP may only step when a result can be accepted at
  // its output. Bubbles are allowed only between frames, so that
  // the remaining final sums drain out. A bubble mid-frame would shift the
  // feedback alignment between passes.
  always_comb begin
    fifo_full     = (fifo_cnt == FULL_CNT);
    fifo_nonempty = (fifo_cnt != '0);
    pop           = fifo_nonempty & bus.out_ready;
    space         = ~fifo_full | pop;
    issue         = ~clr & space & bus.in_valid;
    drain         = ~clr & space & ~bus.in_valid & (lane_cnt == '0) &
                    prev_last & (|tag_valid);
    adv           = issue | drain;
    push          = adv & tag_valid[LATENCY-1] & tag_last[LATENCY-1];
  end

  assign bus.in_ready   = ~clr & space;
  assign bus.ma_a       = issue ? bus.in_a : 32'd0;
  assign bus.ma_b       = issue ? bus.in_b : 32'd0;
  assign bus.ma_chainin = (issue & ~bus.in_first) ? bus.ma_result : 32'd0;
  assign bus.ma_ena     = {3{adv}};
  assign bus.ma_clr0    = clr_q;
  assign bus.ma_clr1    = clr_q;
  assign bus.out_valid  = fifo_nonempty;
  assign bus.out_data   = fifo_nonempty ? fifo_data[rd_ptr] : 32'd0;
  assign bus.out_lane   = fifo_nonempty ? fifo_lane[rd_ptr] : '0;
  assign bus.err_proto  = err_q;

  // Delayed clear for the DSP. Its registers are wiped during the reset
  // cycles and one cycle beyond.
  always_ff @(posedge clk) begin
    clr_q <= clr;
  end

  // Lane counter and frame-flag tracking. A flag that changes anywhere other
  // than lane 0 marks a malformed pass. The beat is still processed.
  always_ff @(posedge clk) begin
    if (clr) begin
      lane_cnt   <= '0;
      prev_first <= 1'b0;
      prev_last  <= 1'b0;
      err_q      <= 1'b0;
    end else if (issue) begin
      lane_cnt   <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + LANE_W'(1);
      prev_first <= bus.in_first;
      prev_last  <= bus.in_last;
      if ((lane_cnt != '0) &&
          ((bus.in_first != prev_first) || (bus.in_last != prev_last)))
        err_q <= 1'b1;
    end
  end

  // Tag pipe control bits. They shift in lockstep with the DSP enable, and
  // a bubble enters as an invalid tag.
  always_ff @(posedge clk) begin
    if (clr) begin
      tag_valid <= '0;
      tag_last  <= '0;
    end else if (adv) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      tag_valid[0] <= issue;
      tag_last[0]  <= issue & bus.in_last;
    end
  end

  // Tag lane indices. These are meaningful only under a valid bit, so they
  // need no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = LATENCY - 1; i > 0; i--)
        tag_lane[i] <= tag_lane[i-1];
      tag_lane[0] <= lane_cnt;
    end
  end

  // FIFO storage. Entries are written only on push, and reads are gated by
  // the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.ma_result;
      fifo_lane[wr_ptr] <= tag_lane[LATENCY-1];
    end
  end

  // FIFO pointers and occupancy. When the FIFO is full, a push can still
  // happen alongside a pop.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      else if (pop && !push)
        fifo_cnt <= fifo_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multadd_fp_ci_seq.sv
// tb_multadd_fp_ci_seq
//   Directed bench for multadd_fp_ci_seq with LATENCY = 4 and FIFO_DEPTH = 8.
//   A 4-stage enabled behavioural DSP computes a*b + chainin and feeds
//   ma_result back. Expected sums are hand-computed fp32 constants.
module tb_multadd_fp_ci_seq;

  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 8;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  multadd_fp_ci_seq_if #(.LANE_W(2)) bus ();

  multadd_fp_ci_seq #(
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  int base;
  int accept_cyc;
  int t0;
  int seen;

  logic [31:0] got_data [$];
  logic [1:0]  got_lane [$];

  // Hand-computed fp32 encodings of the values used below.
  function automatic logic [31:0] fpint(input int n);
    case (n)
      1:  return 32'h3F800000;
      2:  return 32'h40000000;
      3:  return 32'h40400000;
      4:  return 32'h40800000;
      5:  return 32'h40A00000;
      6:  return 32'h40C00000;
      7:  return 32'h40E00000;
      8:  return 32'h41000000;
      9:  return 32'h41100000;
      10: return 32'h41200000;
      11: return 32'h41300000;
      12: return 32'h41400000;
      16: return 32'h41800000;
      default: return 32'h00000000;
    endcase
  endfunction

  // fp32 to real, for the normal and zero operands used here.
  function automatic real fp2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  // real to fp32. The values here are exactly representable, so truncation
  // is exact.
  function automatic logic [31:0] r2fp(input real v);
    logic        s;
    int          e;
    real         m;
    logic [7:0]  eb;
    logic [22:0] mant;
    if (v == 0.0) return 32'd0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    eb   = 8'(e);
    mant = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, eb, mant};
  endfunction

  // Behavioural DSP: four enabled stages, cleared by ma_clr0.
  logic [31:0] dsp_pipe [4] = '{default: 32'd0};
  assign bus.ma_result = dsp_pipe[3];

  always @(posedge clk) begin
    if (bus.ma_clr0) begin
      for (int i = 0; i < 4; i++) dsp_pipe[i] <= 32'd0;
    end else if (bus.ma_ena[0]) begin
      dsp_pipe[0] <= r2fp(fp2r(bus.ma_a) * fp2r(bus.ma_b) + fp2r(bus.ma_chainin));
      for (int i = 1; i < 4; i++) dsp_pipe[i] <= dsp_pipe[i-1];
    end
  end

  // Output monitor. It records every accepted result.
  always @(negedge clk) begin
    if (!clr && bus.out_valid && bus.out_ready) begin
      got_data.push_back(bus.out_data);
      got_lane.push_back(bus.out_lane);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    else
      passed++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one beat and holds it until accepted, with a bounded wait.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic first, input logic last);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_first = first;
    bus.in_last  = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        accept_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) checkOutput("accept timeout", 32'd0, 32'd1);
  endtask

  // Waits for n results since base. It then lingers so that any extra or
  // duplicated result would show up in the count.
  task automatic waitCount(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got_data.size() - base >= n) break;
      idle(1);
    end
    idle(8);
    checkOutput("result count", 32'(got_data.size() - base), 32'(n));
  endtask

  task automatic checkResult(input string tag, input int idx,
                             input logic [31:0] exp_data, input logic [1:0] exp_lane);
    if (base + idx < got_data.size()) begin
      checkOutput($sformatf("%s data%0d", tag, idx), got_data[base+idx], exp_data);
      checkOutput($sformatf("%s lane%0d", tag, idx), 32'(got_lane[base+idx]), 32'(exp_lane));
    end else begin
      checkOutput($sformatf("%s missing%0d", tag, idx), 32'd0, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    clr           = 1'b1;

    // Reset state.
    idle(1);
    checkOutput("rst in_ready",  32'(bus.in_ready),  32'd0);
    checkOutput("rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst out_data",  bus.out_data,       32'd0);
    checkOutput("rst out_lane",  32'(bus.out_lane),  32'd0);
    checkOutput("rst err_proto", 32'(bus.err_proto), 32'd0);
    checkOutput("rst ma_ena",    32'(bus.ma_ena),    32'd0);
    checkOutput("rst ma_clr0",   32'(bus.ma_clr0),   32'd1);
    idle(2);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("post-clr in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post-clr ma_clr1",  32'(bus.ma_clr1),  32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("ma_clr0 released", 32'(bus.ma_clr0), 32'd0);
    @(posedge clk);
    #1;

    // Single-pass frame: a = 1..4, b = 2 gives 2,4,6,8. First result
    // appears 5 cycles after the first accept.
    base = got_data.size();
    for (int l = 0; l < 4; l++) begin
      applyStimulus(fpint(l + 1), fpint(2), 1'b1, 1'b1);
      if (l == 0) t0 = accept_cyc;
    end
    seen = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = cyc;
        break;
      end
    end
    checkOutput("p1 first out latency", 32'(seen - t0), 32'd5);
    @(posedge clk);
    #1;
    waitCount(4, 50);
    for (int l = 0; l < 4; l++)
      checkResult("p1", l, fpint(2 * (l + 1)), 2'(l));

    // Three passes of 1.5*2.0 give 9.0 per lane, with nothing out before
    // the last pass.
    base = got_data.size();
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 4; l++)
        applyStimulus(32'h3FC00000, fpint(2), p == 0, 1'b0);
    idle(6);
    checkOutput("p3 early output", 32'(got_data.size() - base), 32'd0);
    checkOutput("p3 early valid",  32'(bus.out_valid), 32'd0);
    for (int l = 0; l < 4; l++)
      applyStimulus(32'h3FC00000, fpint(2), 1'b0, 1'b1);
    waitCount(4, 50);
    for (int l = 0; l < 4; l++)
      checkResult("p3", l, 32'h41100000, 2'(l));

    // Four passes with random bubbles, a = lane+1 and b = 1, give 4,8,12,16.
    base = got_data.size();
    for (int p = 0; p < 4; p++)
      for (int l = 0; l < 4; l++) begin
        idle(int'($urandom_range(0, 2)));
        applyStimulus(fpint(l + 1), fpint(1), p == 0, p == 3);
      end
    waitCount(4, 50);
    for (int l = 0; l < 4; l++)
      checkResult("gaps", l, fpint(4 * (l + 1)), 2'(l));

    // Backpressure: three single-pass frames with out_ready held low. The
    // FIFO fills and in_ready drops, then all 12 results come out in order.
    bus.out_ready = 1'b0;
    base = got_data.size();
    t0   = cyc;
    for (int k = 0; k < 12; k++)
      applyStimulus(fpint(k + 1), fpint(1), 1'b1, 1'b1);
    if (cyc - t0 < 20) idle(20 - (cyc - t0));
    @(negedge clk);
    checkOutput("bp in_ready",  32'(bus.in_ready),  32'd0);
    checkOutput("bp out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp ma_ena",    32'(bus.ma_ena),    32'd0);
    checkOutput("bp held",      32'(got_data.size() - base), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    waitCount(12, 100);
    for (int k = 0; k < 12; k++)
      checkResult("bp", k, fpint(k + 1), 2'(k % 4));

    // clr after pass 1 of a three-pass frame. Only the fresh frame's sums
    // 5..8 may appear.
    base = got_data.size();
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 4; l++)
        applyStimulus(fpint(3), fpint(1), p == 0, 1'b0);
    clr = 1'b1;
    idle(1);
    @(negedge clk);
    checkOutput("mid clr in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    idle(2);
    for (int l = 0; l < 4; l++)
      applyStimulus(fpint(l + 5), fpint(1), 1'b1, 1'b1);
    waitCount(4, 50);
    for (int l = 0; l < 4; l++)
      checkResult("clr", l, fpint(l + 5), 2'(l));
    checkOutput("clr err_proto", 32'(bus.err_proto), 32'd0);

    // in_last toggled at lane 2 sets err_proto. It stays set until clr.
    applyStimulus(fpint(1), fpint(1), 1'b1, 1'b0);
    applyStimulus(fpint(1), fpint(1), 1'b1, 1'b0);
    checkOutput("err before toggle", 32'(bus.err_proto), 32'd0);
    applyStimulus(fpint(1), fpint(1), 1'b1, 1'b1);
    checkOutput("err at toggle", 32'(bus.err_proto), 32'd1);
    applyStimulus(fpint(1), fpint(1), 1'b1, 1'b0);
    for (int l = 0; l < 4; l++)
      applyStimulus(fpint(1), fpint(1), 1'b0, 1'b1);
    idle(20);
    checkOutput("err sticky", 32'(bus.err_proto), 32'd1);
    clr = 1'b1;
    idle(2);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("err cleared", 32'(bus.err_proto), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
